// File: rtl/decoder_pkg.sv
// Shared types and helpers for decoder output paths: data widths, streamer state
// encoding and the signed fixed-point to 8-bit pixel conversion.
package decoder_pkg;

    localparam int INTEGER_W  = 10;
    localparam int FRACTION_W = 10;
    localparam int DATA_W     = INTEGER_W + FRACTION_W;
    localparam int PIX_W      = 8;
    // Working width for the conversion; must cover data width + 8 for any instance.
    localparam int WIDE_W     = 48;

    localparam logic signed [WIDE_W-1:0] PIX_MAX = 255;
    localparam logic signed [WIDE_W-1:0] PIX_ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Negative values clamp to black; otherwise scale by 255 with round-half-up and saturate.
    function automatic logic [PIX_W-1:0] fixed_to_pixel(input logic signed [WIDE_W-1:0] v,
                                                        input int frac_w);
        logic signed [WIDE_W-1:0] half;
        logic signed [WIDE_W-1:0] acc;
        half = PIX_ONE <<< (frac_w - 1);
        acc  = (v * PIX_MAX + half) >>> frac_w;
        if (v[WIDE_W-1]) begin
            return '0;
        end
        if (acc > PIX_MAX) begin
            return '1;
        end
        return acc[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/decoder_output_streamer_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Head word is visible on rd_data whenever empty is low.
module stream_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A full FIFO may still take a write when the head leaves on the same edge.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/decoder_output_streamer.sv
// Reads the final decoder layer's output BRAM in address order, converts each value
// to an 8-bit pixel and streams it over valid/ready. ROW_LAST_EN adds a pix_last row marker.
module decoder_output_streamer
    import decoder_pkg::*;
#(
    parameter int integer_width  = 10,
    parameter int fraction_width = 10,
    parameter int img_width      = 28,
    parameter int img_height     = 28,
    parameter int addr_width     = 13,
    parameter int read_latency   = 2,
    parameter int fifo_depth     = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    layer_done,
    output logic [addr_width-1:0]                   bram_address,
    output logic                                    bram_enable,
    input  logic [integer_width+fraction_width-1:0] bram_data,
    output logic [PIX_W-1:0]                        pix_data,
    output logic                                    pix_valid,
    input  logic                                    pix_ready,
`ifdef ROW_LAST_EN
    output logic                                    pix_last,
`endif
    output logic                                    frame_done
);

    localparam int TOTAL = img_width * img_height;
    localparam int CNT_W = $clog2(fifo_depth + 1);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(TOTAL - 1);
`ifdef ROW_LAST_EN
    localparam int FIFO_W = PIX_W + 1;
    localparam int COL_W  = (img_width > 1) ? $clog2(img_width) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(img_width - 1);
`else
    localparam int FIFO_W = PIX_W;
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [addr_width-1:0]   rd_addr;
    logic [read_latency-1:0] rd_vld_p;
    int                      inflight;
    logic                    issue;
    logic                    capture;
    logic                    pop;
    logic [PIX_W-1:0]        cap_pix;
    logic [FIFO_W-1:0]       fifo_wr_data;
    logic [FIFO_W-1:0]       fifo_rd_data;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;

    // Credit rule: every issued read already owns a FIFO slot, so capture never overflows.
    always_comb begin
        inflight = $countones(rd_vld_p);
        issue    = (state == FETCH) && ((int'(fifo_count) + inflight) < fifo_depth);
    end

    assign capture = rd_vld_p[read_latency-1];
    assign pop     = pix_valid && pix_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (layer_done) state_nxt = FETCH;
            FETCH:   if (issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
            // Enter DONE on the edge that pops the last pixel so frame_done follows it directly.
            DRAIN:   if ((inflight == 0) &&
                         (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_vld_p <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) rd_addr <= '0;
            else if (issue)    rd_addr <= rd_addr + 1'b1;
            rd_vld_p[0] <= issue;
            for (int i = 1; i < read_latency; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
        end
    end

    assign cap_pix = fixed_to_pixel(WIDE_W'(signed'(bram_data)), fraction_width);

`ifdef ROW_LAST_EN
    logic [COL_W-1:0] col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
        end else if (state == IDLE) begin
            col <= '0;
        end else if (capture) begin
            col <= (col == LAST_COL) ? '0 : col + 1'b1;
        end
    end

    assign fifo_wr_data = {(col == LAST_COL), cap_pix};
    assign pix_last     = !fifo_empty && fifo_rd_data[PIX_W];
`else
    assign fifo_wr_data = cap_pix;
`endif

    stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bram_enable  = issue;
    assign bram_address = rd_addr;
    assign pix_valid    = !fifo_empty;
    assign pix_data     = fifo_empty ? '0 : fifo_rd_data[PIX_W-1:0];
    assign frame_done   = (state == DONE);

    fifo_overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(capture && fifo_full && !pop));

endmodule
